compressed_unpacker: RTL and testbench

Bitstream unpacker on the decompression side of the compression pipeline. It accepts 32-bit packed compressed words and splits them, MSB-first, into variable-length codewords. Codeword lengths follow the compressor's 2-bit code / 2-bit backup-code table. Each codeword is emitted with its code, backup code, right-aligned payload and length to the downstream match/literal decoder over a valid/ready handshake.

---
 rtl/compressed_unpacker_pkg.sv | 30 +++
 rtl/compressed_unpacker_if.sv | 27 ++
 rtl/compressed_unpacker_cw_length.sv | 32 +++
 rtl/compressed_unpacker.sv | 144 ++++++++++++++
 tb/tb_compressed_unpacker.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/compressed_unpacker_pkg.sv
// Shared constants and types for the compressed bitstream unpacker.
package unpacker_pkg;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_LIT  = 2'b01;
    localparam logic [1:0] CODE_FULL = 2'b10;
    localparam logic [1:0] CODE_EXT  = 2'b11;

    localparam logic [1:0] BAK_P20 = 2'b00;
    localparam logic [1:0] BAK_P8  = 2'b01;
    localparam logic [1:0] BAK_P12 = 2'b10;
    localparam logic [1:0] BAK_P28 = 2'b11;

    localparam int unsigned LEN_ZERO    = 2;
    localparam int unsigned LEN_LIT     = 34;
    localparam int unsigned LEN_FULL    = 6;
    localparam int unsigned LEN_EXT_P20 = 24;
    localparam int unsigned LEN_EXT_P8  = 12;
    localparam int unsigned LEN_EXT_P12 = 16;
    localparam int unsigned LEN_EXT_P28 = 32;

    localparam int unsigned HDR_SHORT = 2;
    localparam int unsigned HDR_LONG  = 4;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/compressed_unpacker_if.sv
// Word-input and codeword-output handshake bundle of the unpacker.
interface compressed_unpacker_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              i_last;
    logic              o_ready;
    logic [1:0]        o_code;
    logic [1:0]        o_code_bak;
    logic [DATA_W-1:0] o_payload;
    logic [LEN_W-1:0]  o_len;
    logic              o_valid;
    logic              i_ready;
    logic              o_done;

    modport slave (
        input  i_data, i_valid, i_last, i_ready,
        output o_ready, o_code, o_code_bak, o_payload, o_len, o_valid, o_done
    );

    modport master (
        output i_data, i_valid, i_last, i_ready,
        input  o_ready, o_code, o_code_bak, o_payload, o_len, o_valid, o_done
    );
endinterface

// File: rtl/compressed_unpacker_cw_length.sv
// Combinational codeword length lookup from the top four buffer bits.
module cw_length_decode
    import unpacker_pkg::*;
#(
    parameter int unsigned LEN_W = 6
) (
    input  logic [3:0]       i_top,
    output logic [LEN_W-1:0] o_len,
    output logic [2:0]       o_hdr_w,
    output logic             o_needs_hdr4
);
    always_comb begin
        o_len        = LEN_W'(LEN_ZERO);
        o_hdr_w      = 3'(HDR_SHORT);
        o_needs_hdr4 = 1'b0;
        case (i_top[3:2])
            CODE_ZERO: o_len = LEN_W'(LEN_ZERO);
            CODE_LIT:  o_len = LEN_W'(LEN_LIT);
            CODE_FULL: o_len = LEN_W'(LEN_FULL);
            default: begin
                o_hdr_w      = 3'(HDR_LONG);
                o_needs_hdr4 = 1'b1;
                case (i_top[1:0])
                    BAK_P20: o_len = LEN_W'(LEN_EXT_P20);
                    BAK_P8:  o_len = LEN_W'(LEN_EXT_P8);
                    BAK_P12: o_len = LEN_W'(LEN_EXT_P12);
                    default: o_len = LEN_W'(LEN_EXT_P28);
                endcase
            end
        endcase
    end
endmodule

// File: rtl/compressed_unpacker.sv
// Splits MSB-first packed words into variable-length codewords.
// Define COMPRESSED_UNPACKER_STATS_EN to add saturating codeword/bit counters.
module compressed_unpacker
    import unpacker_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned BUF_W  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    compressed_unpacker_if.slave  bus
`ifdef COMPRESSED_UNPACKER_STATS_EN
    ,
    output logic [15:0]           o_cw_count,
    output logic [23:0]           o_bit_count
`endif
);
    localparam int unsigned CNT_W = 7;

    logic [BUF_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state, w_state_next;
    logic [1:0]        r_code, r_code_bak;
    logic [DATA_W-1:0] r_payload;
    logic [LEN_W-1:0]  r_len;
    logic              r_valid, r_done;

    logic [3:0]        w_top;
    logic [LEN_W-1:0]  w_len, w_plen, w_pay_shamt;
    logic [2:0]        w_hdr_w;
    logic              w_needs_hdr4, w_decodable, w_out_free, w_emit, w_accept, w_drain_end;
    logic [BUF_W-1:0]  w_hdr_sh, w_buf_sh, w_word_ext;
    logic [CNT_W-1:0]  w_cnt_sh, w_need_hdr;
    logic [DATA_W-1:0] w_payload;

    assign w_top = r_buf[BUF_W-1 -: 4];

    cw_length_decode #(.LEN_W(LEN_W)) u_len (
        .i_top        (w_top),
        .o_len        (w_len),
        .o_hdr_w      (w_hdr_w),
        .o_needs_hdr4 (w_needs_hdr4)
    );

    assign w_need_hdr  = w_needs_hdr4 ? CNT_W'(HDR_LONG) : CNT_W'(HDR_SHORT);
    assign w_decodable = (r_count >= w_need_hdr) && (r_count >= CNT_W'(w_len));
    assign w_out_free  = !r_valid || bus.i_ready;
    assign w_emit      = w_decodable && w_out_free;
    assign bus.o_ready = (r_state == ST_RUN) && (r_count <= CNT_W'(DATA_W));
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_drain_end = (r_state == ST_DRAIN) && !w_decodable && w_out_free;

    // Payload sits just below the header; right-align it by shifting the window down.
    assign w_hdr_sh    = r_buf << w_hdr_w;
    assign w_plen      = w_len - LEN_W'(w_hdr_w);
    assign w_pay_shamt = LEN_W'(DATA_W) - w_plen;
    assign w_payload   = w_hdr_sh[BUF_W-1 -: DATA_W] >> w_pay_shamt;

    // A word accepted alongside an emit lands below the post-shift valid bits.
    assign w_buf_sh   = w_emit ? (r_buf << w_len) : r_buf;
    assign w_cnt_sh   = w_emit ? (r_count - CNT_W'(w_len)) : r_count;
    assign w_word_ext = {bus.i_data, {(BUF_W-DATA_W){1'b0}}};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (w_accept && bus.i_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_drain_end)            w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= ST_RUN;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (w_drain_end) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_buf   <= w_buf_sh | (w_word_ext >> w_cnt_sh);
            r_count <= w_cnt_sh + CNT_W'(DATA_W);
        end else begin
            r_buf   <= w_buf_sh;
            r_count <= w_cnt_sh;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_code     <= '0;
            r_code_bak <= '0;
            r_payload  <= '0;
            r_len      <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_drain_end;
            if (w_emit) begin
                r_code     <= w_top[3:2];
                r_code_bak <= (w_top[3:2] == CODE_EXT) ? w_top[1:0] : 2'b00;
                r_payload  <= w_payload;
                r_len      <= w_len;
                r_valid    <= 1'b1;
            end else if (bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.o_code     = r_code;
    assign bus.o_code_bak = r_code_bak;
    assign bus.o_payload  = r_payload;
    assign bus.o_len      = r_len;
    assign bus.o_valid    = r_valid;
    assign bus.o_done     = r_done;

`ifdef COMPRESSED_UNPACKER_STATS_EN
    logic [15:0] r_cw_count;
    logic [23:0] r_bit_count;
    logic [24:0] w_bit_sum;

    assign w_bit_sum = {1'b0, r_bit_count} + 25'(w_len);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cw_count  <= '0;
            r_bit_count <= '0;
        end else if (w_emit) begin
            if (r_cw_count != '1) r_cw_count <= r_cw_count + 16'd1;
            r_bit_count <= w_bit_sum[24] ? '1 : w_bit_sum[23:0];
        end
    end

    assign o_cw_count  = r_cw_count;
    assign o_bit_count = r_bit_count;
`endif
endmodule

// File: tb/tb_compressed_unpacker.sv
// Self-checking bench: bit-queue reference model plus directed and random traffic.
module tb_compressed_unpacker;

    typedef struct packed {
        logic [1:0]  code;
        logic [1:0]  bak;
        logic [31:0] payload;
        logic [5:0]  len;
    } cw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ready_mode = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    compressed_unpacker_if #(.DATA_W(32), .LEN_W(6)) bus ();

`ifdef COMPRESSED_UNPACKER_STATS_EN
    logic [15:0] cw_cnt;
    logic [23:0] bit_cnt;
`endif

    compressed_unpacker #(.DATA_W(32), .LEN_W(6), .BUF_W(64)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
`ifdef COMPRESSED_UNPACKER_STATS_EN
        ,
        .o_cw_count  (cw_cnt),
        .o_bit_count (bit_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    bit   bq[$];
    cw_t  expq[$];
    int   pending_done = 0;
    cw_t  seen[$];
    int   seen_cyc[$];
    int   done_seen = 0;
    logic hold_valid = 1'b0;
    logic [42:0] held;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Greedy MSB-first parse of every complete codeword in the bit queue.
    function automatic void parse();
        while (1) begin
            int n, len, hdr;
            logic [1:0] c, b;
            logic [31:0] p;
            n = bq.size();
            if (n < 2) return;
            c = {bq[0], bq[1]};
            b = 2'b00;
            if (c == 2'b11) begin
                if (n < 4) return;
                b = {bq[2], bq[3]};
                hdr = 4;
                len = (b == 2'b00) ? 24 : (b == 2'b01) ? 12 : (b == 2'b10) ? 16 : 32;
            end else begin
                hdr = 2;
                len = (c == 2'b00) ? 2 : (c == 2'b01) ? 34 : 6;
            end
            if (n < len) return;
            p = '0;
            for (int i = hdr; i < len; i++) p = {p[30:0], bq[i]};
            expq.push_back('{code: c, bak: b, payload: p, len: 6'(len)});
            repeat (len) void'(bq.pop_front());
        end
    endfunction

    always @(negedge clk) begin
        cw_t o;
        o = '{code: bus.o_code, bak: bus.o_code_bak, payload: bus.o_payload, len: bus.o_len};
        if (hold_valid)
            check("hold_stable", {22'd0, o, bus.o_valid}, {22'd0, held});
        if (bus.o_done === 1'b1) begin
            check("done_expected", {62'd0, pending_done > 0, expq.size() == 0}, 64'd3);
            if (pending_done > 0) pending_done--;
            done_seen++;
        end
        if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            if (expq.size() == 0) begin
                check("cw_unexpected", {22'd0, o}, 64'd0 - 64'd1);
            end else begin
                check("cw_fields", {22'd0, o}, {22'd0, expq.pop_front()});
            end
            seen.push_back(o);
            seen_cyc.push_back(cyc);
        end
        hold_valid = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0) && rst_n;
        held = {o, bus.o_valid};
        if (!rst_n) begin
            bq.delete();
            expq.delete();
            pending_done = 0;
        end else if (bus.i_valid === 1'b1 && bus.o_ready === 1'b1) begin
            for (int i = 31; i >= 0; i--) bq.push_back(bus.i_data[i]);
            parse();
            if (bus.i_last) begin
                bq.delete();
                pending_done++;
            end
        end
    end

    initial begin
        forever begin
            case (ready_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'b0;
                default: bus.i_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(posedge clk);
            #1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen.delete();
        seen_cyc.delete();
        done_seen = 0;
    endtask

    task automatic send(input logic [31:0] w, input bit last);
        logic got;
        int   t;
        got = 1'b0;
        t = 0;
        bus.i_data  = w;
        bus.i_valid = 1'b1;
        bus.i_last  = last;
        while (!got && t < 300) begin
            @(negedge clk);
            got = bus.o_ready;
            @(posedge clk);
            #1;
            t++;
        end
        check("send_accept", {63'd0, got}, 64'd1);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 1000 && !(pending_done == 0 && expq.size() == 0 && bus.o_valid === 1'b0)) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle_reached", {63'd0, t < 1000}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_low;
        bus.i_data  = '0;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid",   {63'd0, bus.o_valid}, 64'd0);
        check("rst_code",    {60'd0, bus.o_code, bus.o_code_bak}, 64'd0);
        check("rst_payload", {32'd0, bus.o_payload}, 64'd0);
        check("rst_len",     {58'd0, bus.o_len}, 64'd0);
        check("rst_done",    {63'd0, bus.o_done}, 64'd0);
        check("rst_ready",   {63'd0, bus.o_ready}, 64'd1);

        // All-zero word: 16 two-bit codewords back to back
        send(32'h0000_0000, 1'b1);
        @(posedge clk);
        #1;
        check("latency_valid", {63'd0, bus.o_valid}, 64'd1);
        wait_idle();
        check("s1_count", 64'(seen.size()), 64'd16);
        if (seen.size() == 16) begin
            check("s1_first", {22'd0, seen[0]}, {22'd0, 2'b00, 2'b00, 32'd0, 6'd2});
            check("s1_throughput", 64'(seen_cyc[15] - seen_cyc[0]), 64'd15);
        end
        check("s1_done", 64'(done_seen), 64'd1);

        // Literal codeword straddling two words
        do_reset();
        send(32'h77AB_6FBB, 1'b0);
        send(32'hC000_0000, 1'b1);
        wait_idle();
        check("s2_count", 64'(seen.size()), 64'd16);
        if (seen.size() >= 2) begin
            check("s2_first",  {22'd0, seen[0]}, {22'd0, 2'b01, 2'b00, 32'hDEAD_BEEF, 6'd34});
            check("s2_second", {22'd0, seen[1]}, {22'd0, 2'b00, 2'b00, 32'd0, 6'd2});
        end
        check("s2_done", 64'(done_seen), 64'd1);
`ifdef COMPRESSED_UNPACKER_STATS_EN
        check("stats_cw",  {48'd0, cw_cnt}, 64'd16);
        check("stats_bit", {40'd0, bit_cnt}, 64'd64);
`endif

        // Extended code with 4-bit header
        do_reset();
        send(32'hDA50_0000, 1'b1);
        wait_idle();
        check("s3_count", 64'(seen.size()), 64'd11);
        if (seen.size() >= 1)
            check("s3_first", {22'd0, seen[0]}, {22'd0, 2'b11, 2'b01, 32'h0000_00A5, 6'd12});

        // Downstream stall: fields hold, o_ready backs off, nothing lost
        do_reset();
        ready_mode = 1;
        saw_low = 1'b0;
        bus.i_data  = '0;
        bus.i_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_ready === 1'b0) saw_low = 1'b1;
        end
        check("stall_ready_low", {63'd0, saw_low}, 64'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        ready_mode = 0;
        send(32'h0000_0000, 1'b1);
        wait_idle();
        check("stall_done", 64'(done_seen), 64'd1);

        // Reset while draining with residual bits buffered
        do_reset();
        ready_mode = 1;
        send(32'hDA50_0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("drain_held_valid", {63'd0, bus.o_valid}, 64'd1);
        check("drain_ready_low",  {63'd0, bus.o_ready}, 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        check("mid_rst_valid", {63'd0, bus.o_valid}, 64'd0);
        check("mid_rst_fields", {22'd0, bus.o_code, bus.o_code_bak, bus.o_payload, bus.o_len}, 64'd0);
        check("mid_rst_ready", {63'd0, bus.o_ready}, 64'd1);
        done_seen = 0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(done_seen), 64'd0);

        // Randomized traffic with random downstream backpressure
        do_reset();
        ready_mode = 2;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] w;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            w = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            send(w, (k == 299) || ($urandom_range(0, 7) == 0));
        end
        wait_idle();
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
